// File: rtl/pc_unit.sv
// Next-PC selection with branch decode, JAL/JALR, stall/redirect, misaligned-target trap and
// a circular return-address stack. Optional 16-bit instruction support: PC_UNIT_COMPRESSED_EN.
module pc_unit #(
   parameter int unsigned       XLEN         = 32,
   parameter logic [XLEN-1:0]   RESET_VECTOR = 32'h0000_0000,
   parameter logic [XLEN-1:0]   TRAP_VECTOR  = 32'h0000_0100,
   parameter int unsigned       RAS_DEPTH    = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           stall,
   input  logic                           redirect_valid,
   input  logic [XLEN-1:0]                redirect_pc,
   input  logic                           branch,
   input  logic [2:0]                     funct3,
   input  logic                           zero,
   input  logic                           lt,
   input  logic                           ltu,
   input  logic                           jal,
   input  logic                           jalr,
   input  logic [XLEN-1:0]                imm,
   input  logic [XLEN-1:0]                rs1,
   input  logic                           is_call,
   input  logic                           is_ret,
   input  logic                           is_compressed,
   output logic [XLEN-1:0]                pc,
   output logic [XLEN-1:0]                pc_link,
   output logic                           taken,
   output logic                           misalign,
   output logic [XLEN-1:0]                ras_top,
   output logic                           ras_valid,
   output logic [$clog2(RAS_DEPTH):0]     ras_count
);

   localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [2:0] {
      SrcRedirect,
      SrcHold,
      SrcJalr,
      SrcJal,
      SrcBranch,
      SrcSeq
   } next_src_e;

   logic [XLEN-1:0]  pc_q, pc_d;
   logic             misalign_q;
   logic [XLEN-1:0]  ras_mem_q [RAS_DEPTH];
   logic [PTR_W-1:0] ras_ptr_q, ras_ptr_d;
   logic [CNT_W-1:0] ras_cnt_q, ras_cnt_d;

   next_src_e        src;
   logic             branch_cond;
   logic [XLEN-1:0]  link;
   logic [XLEN-1:0]  pc_imm;
   logic [XLEN-1:0]  jalr_sum;
   logic [XLEN-1:0]  jalr_tgt;
   logic [XLEN-1:0]  ctrl_tgt;
   logic             ctrl_sel;
   logic             misaligned;

   logic             ras_en;
   logic             do_push;
   logic             do_pop;
   logic             ras_empty;
   logic             ras_full;
   logic [PTR_W-1:0] top_idx;
   logic             ras_wr_en;
   logic [PTR_W-1:0] ras_wr_idx;

   // ---------------------------------------------------------------------------------------------
   // Branch condition and target arithmetic
   // ---------------------------------------------------------------------------------------------
   always_comb begin
      branch_cond = 1'b0;
      case (funct3)
         3'b000:  branch_cond = zero;
         3'b001:  branch_cond = !zero;
         3'b100:  branch_cond = lt;
         3'b101:  branch_cond = !lt;
         3'b110:  branch_cond = ltu;
         3'b111:  branch_cond = !ltu;
         default: branch_cond = 1'b0;
      endcase
   end

`ifdef PC_UNIT_COMPRESSED_EN
   assign link = pc_q + (is_compressed ? XLEN'(2) : XLEN'(4));
`else
   logic unused_is_compressed;
   assign unused_is_compressed = is_compressed;
   assign link = pc_q + XLEN'(4);
`endif

   assign pc_imm   = pc_q + imm;
   assign jalr_sum = rs1 + imm;
   assign jalr_tgt = {jalr_sum[XLEN-1:1], 1'b0};

   // ---------------------------------------------------------------------------------------------
   // Next-PC selection
   // ---------------------------------------------------------------------------------------------
   always_comb begin
      src = SrcSeq;
      if (redirect_valid) begin
         src = SrcRedirect;
      end else if (stall) begin
         src = SrcHold;
      end else if (jalr) begin
         src = SrcJalr;
      end else if (jal) begin
         src = SrcJal;
      end else if (branch && branch_cond) begin
         src = SrcBranch;
      end
   end

   assign ctrl_sel = (src == SrcJalr) || (src == SrcJal) || (src == SrcBranch);
   assign ctrl_tgt = (src == SrcJalr) ? jalr_tgt : pc_imm;

`ifdef PC_UNIT_COMPRESSED_EN
   assign misaligned = ctrl_sel && ctrl_tgt[0];
`else
   assign misaligned = ctrl_sel && (ctrl_tgt[1:0] != 2'b00);
`endif

   always_comb begin
      pc_d = link;
      case (src)
         SrcRedirect: pc_d = redirect_pc;
         SrcHold:     pc_d = pc_q;
         SrcJalr,
         SrcJal,
         SrcBranch:   pc_d = misaligned ? TRAP_VECTOR : ctrl_tgt;
         default:     pc_d = link;
      endcase
   end

   assign taken = (src == SrcRedirect) || ctrl_sel;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q       <= RESET_VECTOR;
         misalign_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         misalign_q <= misaligned;
      end
   end

   // ---------------------------------------------------------------------------------------------
   // Return-address stack: ras_ptr_q is the next free slot, so the top lives at ras_ptr_q - 1.
   // ---------------------------------------------------------------------------------------------
   assign ras_en    = !stall && !redirect_valid && !misaligned;
   assign do_push   = ras_en && is_call && (jal || jalr);
   assign do_pop    = ras_en && is_ret && jalr;
   assign ras_empty = (ras_cnt_q == '0);
   assign ras_full  = (ras_cnt_q == CNT_W'(RAS_DEPTH));
   assign top_idx   = ras_ptr_q - PTR_W'(1);

   always_comb begin
      ras_ptr_d  = ras_ptr_q;
      ras_cnt_d  = ras_cnt_q;
      ras_wr_en  = 1'b0;
      ras_wr_idx = ras_ptr_q;
      if (do_push && do_pop && !ras_empty) begin
         // Pop-then-push collapses to overwriting the top in place.
         ras_wr_en  = 1'b1;
         ras_wr_idx = top_idx;
      end else if (do_push) begin
         ras_wr_en  = 1'b1;
         ras_ptr_d  = ras_ptr_q + PTR_W'(1);
         ras_cnt_d  = ras_full ? ras_cnt_q : ras_cnt_q + CNT_W'(1);
      end else if (do_pop && !ras_empty) begin
         ras_ptr_d  = top_idx;
         ras_cnt_d  = ras_cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ras_ptr_q <= '0;
         ras_cnt_q <= '0;
      end else begin
         ras_ptr_q <= ras_ptr_d;
         ras_cnt_q <= ras_cnt_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
            ras_mem_q[i] <= '0;
         end
      end else if (ras_wr_en) begin
         ras_mem_q[ras_wr_idx] <= link;
      end
   end

   assign pc        = pc_q;
   assign pc_link   = link;
   assign misalign  = misalign_q;
   assign ras_top   = ras_mem_q[top_idx];
   assign ras_valid = !ras_empty;
   assign ras_count = ras_cnt_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed and randomized bench for pc_unit against a queue-based reference model.
module tb_pc_unit;

   localparam logic [31:0] TRAP = 32'h0000_0100;
   localparam int          DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall, redirect_valid, branch, zero, lt, ltu, jal, jalr;
   logic        is_call, is_ret, is_compressed;
   logic [2:0]  funct3;
   logic [31:0] redirect_pc, imm, rs1;
   logic [31:0] pc, pc_link, ras_top;
   logic        taken, misalign, ras_valid;
   logic [2:0]  ras_count;

   int total = 0;
   int bad   = 0;

   logic [31:0] m_pc;
   logic [31:0] m_ras [$];

   pc_unit dut (
      .clk            (clk),
      .reset          (reset),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .branch         (branch),
      .funct3         (funct3),
      .zero           (zero),
      .lt             (lt),
      .ltu            (ltu),
      .jal            (jal),
      .jalr           (jalr),
      .imm            (imm),
      .rs1            (rs1),
      .is_call        (is_call),
      .is_ret         (is_ret),
      .is_compressed  (is_compressed),
      .pc             (pc),
      .pc_link        (pc_link),
      .taken          (taken),
      .misalign       (misalign),
      .ras_top        (ras_top),
      .ras_valid      (ras_valid),
      .ras_count      (ras_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      stall = 0; redirect_valid = 0; redirect_pc = 0; branch = 0; funct3 = 0;
      zero = 0; lt = 0; ltu = 0; jal = 0; jalr = 0; imm = 0; rs1 = 0;
      is_call = 0; is_ret = 0; is_compressed = 0;
   endtask

   // Called at a falling edge with inputs applied; returns at the next falling edge.
   task automatic step();
      logic [31:0] link, tgt, nxt;
      bit          cond, ctl, tk, mis;
`ifdef PC_UNIT_COMPRESSED_EN
      link = m_pc + (is_compressed ? 32'd2 : 32'd4);
`else
      link = m_pc + 32'd4;
`endif
      case (funct3)
         3'd0: cond = !zero ? 1'b0 : 1'b1;
         3'd1: cond = !zero;
         3'd4: cond = lt;
         3'd5: cond = !lt;
         3'd6: cond = ltu;
         3'd7: cond = !ltu;
         default: cond = 0;
      endcase
      ctl = 0; tk = 0; nxt = link; tgt = 0;
      if (redirect_valid) begin
         nxt = redirect_pc; tk = 1;
      end else if (stall) begin
         nxt = m_pc;
      end else if (jalr) begin
         tgt = (rs1 + imm) & 32'hFFFF_FFFE; ctl = 1;
      end else if (jal) begin
         tgt = m_pc + imm; ctl = 1;
      end else if (branch && cond) begin
         tgt = m_pc + imm; ctl = 1;
      end
      if (ctl) begin
         tk = 1; nxt = tgt;
      end
`ifdef PC_UNIT_COMPRESSED_EN
      mis = ctl && tgt[0];
`else
      mis = ctl && (tgt[1:0] != 2'b00);
`endif
      if (mis) nxt = TRAP;
      #1;
      check("taken", {31'b0, taken}, {31'b0, tk});
      check("pc_link", pc_link, link);
      if (!redirect_valid && !stall && !mis) begin
         if (is_call && is_ret && jalr) begin
            if (m_ras.size() > 0) void'(m_ras.pop_back());
            m_ras.push_back(link);
         end else if (is_call && (jal || jalr)) begin
            m_ras.push_back(link);
            if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
         end else if (is_ret && jalr) begin
            if (m_ras.size() > 0) void'(m_ras.pop_back());
         end
      end
      @(posedge clk);
      #1;
      m_pc = nxt;
      check("pc", pc, m_pc);
      check("misalign", {31'b0, misalign}, {31'b0, mis});
      check("ras_count", {29'b0, ras_count}, m_ras.size());
      check("ras_valid", {31'b0, ras_valid}, {31'b0, m_ras.size() != 0});
      if (m_ras.size() > 0) check("ras_top", ras_top, m_ras[$]);
      @(negedge clk);
   endtask

   task automatic go_to(input logic [31:0] target);
      idle();
      redirect_valid = 1; redirect_pc = target;
      step();
      idle();
   endtask

   initial begin
      logic [31:0] r;
      idle();
      reset = 1;
      repeat (2) @(negedge clk);
      check("rst_pc", pc, 32'h0);
      check("rst_misalign", {31'b0, misalign}, 32'h0);
      check("rst_ras_count", {29'b0, ras_count}, 32'h0);
      check("rst_ras_top", ras_top, 32'h0);
      reset = 0;
      m_pc = 0;

      for (int i = 0; i < 3; i++) begin
         step();
         check("seq_pc", pc, 32'(4 * (i + 1)));
      end

      go_to(32'h20);
      branch = 1; funct3 = 3'b001; zero = 0; imm = 32'hFFFF_FFF0;
      step();
      check("bne_taken_pc", pc, 32'h10);
      go_to(32'h20);
      branch = 1; funct3 = 3'b001; zero = 1; imm = 32'hFFFF_FFF0;
      step();
      check("bne_fall_pc", pc, 32'h24);

      go_to(32'h40);
      jal = 1; is_call = 1; imm = 32'h100;
      step();
      check("call_pc", pc, 32'h140);
      check("call_top", ras_top, 32'h44);
      check("call_count", {29'b0, ras_count}, 32'd1);
      idle();
      jalr = 1; is_ret = 1; rs1 = 32'h44;
      step();
      check("ret_pc", pc, 32'h44);
      check("ret_count", {29'b0, ras_count}, 32'd0);

      for (int i = 0; i < 5; i++) begin
         idle(); jal = 1; is_call = 1; imm = 32'h10;
         step();
      end
      check("ras_sat", {29'b0, ras_count}, 32'd4);
      for (int i = 0; i < 5; i++) begin
         idle(); jalr = 1; is_ret = 1; rs1 = 32'h200;
         step();
      end
      check("ras_drain", {29'b0, ras_count}, 32'd0);

      go_to(32'h10);
      jal = 1; is_call = 1; imm = 32'h6;
      step();
`ifndef PC_UNIT_COMPRESSED_EN
      check("mis_pc", pc, TRAP);
      check("mis_pulse", {31'b0, misalign}, 32'd1);
`endif
      idle();
      step();
      check("mis_drop", {31'b0, misalign}, 32'd0);

      stall = 1; jal = 1; is_call = 1; imm = 32'h40;
      step();
      stall = 1; redirect_valid = 1; redirect_pc = 32'h800;
      step();
      check("stall_redirect_pc", pc, 32'h800);

      for (int i = 0; i < 2000; i++) begin
         if (i == 1000) begin
            reset = 1;
            #1;
            check("midrun_rst_pc", pc, 32'h0);
            check("midrun_rst_count", {29'b0, ras_count}, 32'd0);
            m_pc = 0;
            m_ras.delete();
            @(negedge clk);
            reset = 0;
         end
         idle();
         r = $urandom;
         stall          = ($urandom_range(0, 9) == 0);
         redirect_valid = ($urandom_range(0, 15) == 0);
         redirect_pc    = $urandom & 32'h0000_FFFC;
         branch         = r[0];
         funct3         = r[3:1];
         zero           = r[4];
         lt             = r[5];
         ltu            = r[6];
         jal            = ($urandom_range(0, 4) == 0);
         jalr           = ($urandom_range(0, 4) == 0);
         is_call        = ($urandom_range(0, 2) == 0);
         is_ret         = ($urandom_range(0, 2) == 0);
         is_compressed  = r[7];
         imm            = {{20{r[19]}}, r[19:8]};
         if ($urandom_range(0, 7) != 0) imm[1:0] = 2'b00;
         rs1            = $urandom & 32'h0000_FFFC;
         if ($urandom_range(0, 7) == 0) rs1[1] = 1'b1;
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
